// File: rtl/ccff_chain_loader_pkg.sv
// ---------------------------------------------------------------------------
// Package ccff_pkg
// Shared definitions for the configuration-chain loader:
//   state_t     - loader sequencing states
//   CRC_POLY    - CRC-16-CCITT polynomial
//   CRC_INIT    - CRC seed loaded at the start of every sequence
//   crc16_step  - one serial, MSB-first, non-reflected CRC update
// ---------------------------------------------------------------------------
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Absorb one bit: the feedback is the outgoing MSB xor the new bit,
    // and a set feedback folds the polynomial into the shifted register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// Interface ccff_chain_loader_if
// Host-to-loader bitstream word stream (valid/ready).
//   word_data   host word, MSB is shifted into the chain first
//   word_valid  word_data is valid
//   word_ready  loader takes word_data this cycle
// Modports: master = host/DMA side, slave = loader side.
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_chain_loader_crc16.sv
// ---------------------------------------------------------------------------
// Module ccff_crc16_serial
// Bit-serial CRC-16-CCITT accumulator.
//   clk, rst_n  clock and asynchronous active-low reset (register resets to 0)
//   clear       reload the seed CRC_INIT (wins over en)
//   en          absorb bit_in this cycle
//   bit_in      serial data bit
//   crc         current CRC value
// ---------------------------------------------------------------------------
module ccff_crc16_serial
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    // Seed on clear so each load+verify sequence starts from the same value,
    // otherwise fold in one bit whenever the owner says a bit is on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// Module ccff_chain_loader
// Loads one configuration chain from host words, then recirculates the chain
// once (tail -> head) and compares a CRC of what came out of the tail with a
// CRC of what was shifted in.
//   prog_clk      configuration clock
//   prog_reset_n  asynchronous active-low reset
//   start         1-cycle pulse, begins a sequence when idle
//   host          word stream (slave modport: word_data/word_valid in, word_ready out)
//   ccff_head     serial data into the chain head
//   ccff_tail     serial data from the chain tail
//   chain_clk_en  chain clock-gate enable; the chain shifts only when 1
//   busy          sequence in progress
//   done          1-cycle pulse at sequence end
//   crc_ok        sticky verify result, cleared by the next accepted start
// ---------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 40
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    ccff_chain_loader_if.slave  host,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                chain_clk_en,
    output logic                busy,
    output logic                done,
    output logic                crc_ok
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   shreg;
    logic [IDX_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    bit_cnt;
    logic [15:0]         crc_tx;
    logic [15:0]         crc_rx;
    logic                seq_start;
    logic                word_last;
    logic                chain_last;
    logic                tx_en;
    logic                rx_en;

    assign seq_start  = (state == IDLE) && start;
    assign word_last  = (bit_idx == IDX_W'(WORD_W - 1));
    assign chain_last = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign tx_en      = (state == SHIFT);
    assign rx_en      = (state == VERIFY);
    assign busy       = (state != IDLE);

    // State register. Reset drops straight to IDLE, so every output decoded
    // from the state goes low in the same cycle and no done pulse is produced.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and chain-side outputs. The same bit counter measures the
    // load phase and then the recirculation phase; it is zeroed on the last
    // load bit so VERIFY follows SHIFT with no gap. During VERIFY the head is
    // a combinational copy of the tail so the chain returns to its image.
    always_comb begin
        next_state      = state;
        host.word_ready = 1'b0;
        chain_clk_en    = 1'b0;
        ccff_head       = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                host.word_ready = 1'b1;
                if (host.word_valid) next_state = SHIFT;
            end
            SHIFT: begin
                chain_clk_en = 1'b1;
                ccff_head    = shreg[WORD_W-1];
                if (chain_last) begin
                    next_state = VERIFY;
                end else if (word_last) begin
                    next_state = FETCH;
                end
            end
            VERIFY: begin
                chain_clk_en = 1'b1;
                ccff_head    = ccff_tail;
                if (chain_last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: word capture, MSB-first serialisation, bit counting and the
    // sticky verify flag. Leftover bits of the final word are simply dropped
    // when the counter says the chain is full.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            crc_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        crc_ok  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (host.word_valid) begin
                        shreg   <= host.word_data;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_idx <= bit_idx + IDX_W'(1);
                    bit_cnt <= chain_last ? '0 : bit_cnt + CNT_W'(1);
                end
                VERIFY: begin
                    bit_cnt <= chain_last ? '0 : bit_cnt + CNT_W'(1);
                end
                DONE: begin
                    crc_ok <= (crc_rx == crc_tx);
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    ccff_crc16_serial u_crc_tx (
        .clk    (prog_clk),
        .rst_n  (prog_reset_n),
        .clear  (seq_start),
        .en     (tx_en),
        .bit_in (shreg[WORD_W-1]),
        .crc    (crc_tx)
    );

    ccff_crc16_serial u_crc_rx (
        .clk    (prog_clk),
        .rst_n  (prog_reset_n),
        .clear  (seq_start),
        .en     (rx_en),
        .bit_in (ccff_tail),
        .crc    (crc_rx)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// Testbench for ccff_chain_loader. Two loaders share clock and reset:
// dut_a (CHAIN_LEN=40, WORD_W=32) and dut_b (CHAIN_LEN=32, WORD_W=32).
// Each chain is modelled as a shift register clocked on enabled edges.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

    localparam int WORD_W = 32;
    localparam int LEN_A  = 40;
    localparam int LEN_B  = 32;

    typedef struct {
        logic [LEN_A-1:0] image;
        logic             ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a;
    logic start_b;

    logic head_a, en_a, busy_a, done_a, crc_ok_a, tail_a;
    logic head_b, en_b, busy_b, done_b, crc_ok_b, tail_b;

    logic [LEN_A-1:0] chain_a = '0;
    logic [LEN_A-1:0] nxt_a;
    logic [LEN_B-1:0] chain_b = '0;

    int shift_cnt_a = 0;
    int word_cnt_a  = 0;
    int done_cnt_a  = 0;
    int shift_cnt_b = 0;
    int word_cnt_b  = 0;
    int ready_cnt_b = 0;
    int done_cnt_b  = 0;

    logic corrupt_arm = 1'b0;
    int   corrupt_at  = 0;

    exp_t exp_q[$];
    exp_t exp_b_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) bus_a ();
    ccff_chain_loader_if #(.WORD_W(WORD_W)) bus_b ();

    assign tail_a = chain_a[LEN_A-1];
    assign tail_b = chain_b[LEN_B-1];

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_A)) dut_a (
        .prog_clk     (clk),
        .prog_reset_n (rst_n),
        .start        (start_a),
        .host         (bus_a.slave),
        .ccff_head    (head_a),
        .ccff_tail    (tail_a),
        .chain_clk_en (en_a),
        .busy         (busy_a),
        .done         (done_a),
        .crc_ok       (crc_ok_a)
    );

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_B)) dut_b (
        .prog_clk     (clk),
        .prog_reset_n (rst_n),
        .start        (start_b),
        .host         (bus_b.slave),
        .ccff_head    (head_b),
        .ccff_tail    (tail_b),
        .chain_clk_en (en_b),
        .busy         (busy_b),
        .done         (done_b),
        .crc_ok       (crc_ok_b)
    );

    // Chain A model plus handshake/done counters. When armed, one bit is
    // flipped right after the last load shift to emulate an upset in the chain.
    always @(posedge clk) begin
        if (en_a === 1'b1) begin
            nxt_a = {chain_a[LEN_A-2:0], head_a};
            if (corrupt_arm && (shift_cnt_a + 1 == corrupt_at)) nxt_a[0] = ~nxt_a[0];
            chain_a     <= nxt_a;
            shift_cnt_a <= shift_cnt_a + 1;
        end
        if (bus_a.word_valid === 1'b1 && bus_a.word_ready === 1'b1) word_cnt_a <= word_cnt_a + 1;
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    // Chain B model and counters, including how often word_ready was high.
    always @(posedge clk) begin
        if (en_b === 1'b1) begin
            chain_b     <= {chain_b[LEN_B-2:0], head_b};
            shift_cnt_b <= shift_cnt_b + 1;
        end
        if (bus_b.word_ready === 1'b1) ready_cnt_b <= ready_cnt_b + 1;
        if (bus_b.word_valid === 1'b1 && bus_b.word_ready === 1'b1) word_cnt_b <= word_cnt_b + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    // Safety net so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset_state();
        #1;
        tests_run++;
        if ({head_a, en_a, busy_a, done_a, crc_ok_a, bus_a.word_ready} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs_a: got %b expected 000000",
                     {head_a, en_a, busy_a, done_a, crc_ok_a, bus_a.word_ready});
        end
        tests_run++;
        if ({head_b, en_b, busy_b, done_b, crc_ok_b, bus_b.word_ready} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs_b: got %b expected 000000",
                     {head_b, en_b, busy_b, done_b, crc_ok_b, bus_b.word_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one full sequence on dut_a with two words and checks it end to end.
    task automatic run_seq_a(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                             input int stall, input logic mid_start, input logic corrupt,
                             input string tag);
        int   base_w, base_d, base_s, cyc;
        logic seen;
        exp_t e;
        exp_q.push_back('{image: {w0, w1[WORD_W-1 -: (LEN_A - WORD_W)]} ^ {{(LEN_A-1){1'b0}}, corrupt},
                          ok: ~corrupt});
        base_w = word_cnt_a;
        base_d = done_cnt_a;
        base_s = shift_cnt_a;
        if (corrupt) begin
            corrupt_at  = base_s + LEN_A;
            corrupt_arm = 1'b1;
        end
        start_a            = 1'b1;
        bus_a.word_valid   = 1'b1;
        bus_a.word_data    = w0;
        @(negedge clk);
        start_a = 1'b0;
        tests_run++;
        if (bus_a.word_ready !== 1'b1 || en_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s fetch_cycle: ready=%b en=%b expected ready=1 en=0", tag, bus_a.word_ready, en_a);
        end
        @(negedge clk);
        bus_a.word_valid = 1'b0;
        tests_run++;
        if (en_a !== 1'b1 || busy_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s first_enable_latency: en=%b busy=%b expected 1 1", tag, en_a, busy_a);
        end
        cyc = 0;
        while (bus_a.word_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (bus_a.word_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s word2_ready_timeout: ready=%b expected 1", tag, bus_a.word_ready);
        end
        for (int i = 0; i < stall; i++) begin
            tests_run++;
            if (en_a !== 1'b0 || bus_a.word_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s stall_cycle%0d: en=%b ready=%b expected en=0 ready=1",
                         tag, i, en_a, bus_a.word_ready);
            end
            @(negedge clk);
        end
        bus_a.word_valid = 1'b1;
        bus_a.word_data  = w1;
        @(negedge clk);
        bus_a.word_valid = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            start_a = (mid_start && cyc == 20);
            @(negedge clk);
            cyc++;
            if (done_a === 1'b1) seen = 1'b1;
        end
        start_a = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s done_timeout: done never seen within 300 cycles", tag);
        end
        tests_run++;
        if (en_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s enable_in_done: en=%b expected 0", tag, en_a);
        end
        @(negedge clk);
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s after_done: done=%b busy=%b expected 0 0", tag, done_a, busy_a);
        end
        repeat (5) @(negedge clk);
        corrupt_arm = 1'b0;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard_empty: no expectation queued", tag);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (crc_ok_a !== e.ok) begin
                tests_failed++;
                $display("[TB] FAIL %s crc_ok: got %b expected %b", tag, crc_ok_a, e.ok);
            end
            tests_run++;
            if (chain_a !== e.image) begin
                tests_failed++;
                $display("[TB] FAIL %s chain_image: got %h expected %h", tag, chain_a, e.image);
            end
        end
        tests_run++;
        if (done_cnt_a - base_d !== 1) begin
            tests_failed++;
            $display("[TB] FAIL %s done_pulses: got %0d expected 1", tag, done_cnt_a - base_d);
        end
        tests_run++;
        if (word_cnt_a - base_w !== 2) begin
            tests_failed++;
            $display("[TB] FAIL %s words_consumed: got %0d expected 2", tag, word_cnt_a - base_w);
        end
        tests_run++;
        if (shift_cnt_a - base_s !== 2 * LEN_A) begin
            tests_failed++;
            $display("[TB] FAIL %s enable_cycles: got %0d expected %0d", tag, shift_cnt_a - base_s, 2 * LEN_A);
        end
    endtask

    task automatic test_nominal();
        run_seq_a(32'hA5A5_F00F, {8'hC3, 24'($urandom)}, 0, 1'b0, 1'b0, "nominal");
    endtask

    task automatic test_reset_mid_shift();
        int base_d;
        base_d           = done_cnt_a;
        start_a          = 1'b1;
        bus_a.word_valid = 1'b1;
        bus_a.word_data  = 32'h1357_9BDF;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        bus_a.word_valid = 1'b0;
        tests_run++;
        if (crc_ok_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL crc_ok_cleared_on_start: got %b expected 0", crc_ok_a);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({head_a, en_a, busy_a, done_a, crc_ok_a, bus_a.word_ready} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_shift_outputs: got %b expected 000000",
                     {head_a, en_a, busy_a, done_a, crc_ok_a, bus_a.word_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || bus_a.word_ready !== 1'b0 || en_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: busy=%b ready=%b en=%b expected 0 0 0",
                     busy_a, bus_a.word_ready, en_a);
        end
        tests_run++;
        if (done_cnt_a - base_d !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_done: got %0d done pulses expected 0", done_cnt_a - base_d);
        end
    endtask

    task automatic test_backpressure();
        run_seq_a(32'hA5A5_F00F, {8'hC3, 24'($urandom)}, 7, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_corruption();
        run_seq_a(32'hA5A5_F00F, {8'hC3, 24'($urandom)}, 0, 1'b0, 1'b1, "corruption");
    endtask

    task automatic test_start_while_busy();
        run_seq_a($urandom, $urandom, 0, 1'b1, 1'b0, "start_busy");
    endtask

    task automatic test_boundary();
        logic [WORD_W-1:0] w;
        int   base_w, base_r, base_d, run, cyc;
        exp_t e;
        w = $urandom;
        exp_b_q.push_back('{image: {{(LEN_A-LEN_B){1'b0}}, w}, ok: 1'b1});
        base_w           = word_cnt_b;
        base_r           = ready_cnt_b;
        base_d           = done_cnt_b;
        start_b          = 1'b1;
        bus_b.word_valid = 1'b1;
        bus_b.word_data  = w;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (en_b !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        run = 0;
        while (en_b === 1'b1 && run < 200) begin
            run++;
            @(negedge clk);
        end
        tests_run++;
        if (run !== 2 * LEN_B) begin
            tests_failed++;
            $display("[TB] FAIL boundary_enable_run: got %0d contiguous cycles expected %0d", run, 2 * LEN_B);
        end
        tests_run++;
        if (done_b !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL boundary_done_after_verify: done=%b expected 1", done_b);
        end
        bus_b.word_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ready_cnt_b - base_r !== 1 || word_cnt_b - base_w !== 1) begin
            tests_failed++;
            $display("[TB] FAIL boundary_single_fetch: ready_cycles=%0d words=%0d expected 1 1",
                     ready_cnt_b - base_r, word_cnt_b - base_w);
        end
        tests_run++;
        if (done_cnt_b - base_d !== 1) begin
            tests_failed++;
            $display("[TB] FAIL boundary_done_pulses: got %0d expected 1", done_cnt_b - base_d);
        end
        e = exp_b_q.pop_front();
        tests_run++;
        if (crc_ok_b !== e.ok) begin
            tests_failed++;
            $display("[TB] FAIL boundary_crc_ok: got %b expected %b", crc_ok_b, e.ok);
        end
        tests_run++;
        if (chain_b !== e.image[LEN_B-1:0]) begin
            tests_failed++;
            $display("[TB] FAIL boundary_chain_image: got %h expected %h", chain_b, e.image[LEN_B-1:0]);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        start_a          = 1'b0;
        start_b          = 1'b0;
        bus_a.word_valid = 1'b0;
        bus_a.word_data  = '0;
        bus_b.word_valid = 1'b0;
        bus_b.word_data  = '0;
        test_reset_state();
        test_nominal();
        test_reset_mid_shift();
        test_backpressure();
        test_corruption();
        test_start_while_busy();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
